// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational read ports, two prioritised
// synchronous write ports, optional write-to-read forwarding and a
// per-entry pending scoreboard. Reset kicks off a one-entry-per-cycle clear sweep.
module regfile_mp #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   output logic              init_busy,
   // read ports
   input  logic [ADDR_W-1:0] A1,
   input  logic [ADDR_W-1:0] A2,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   output logic              pend1,
   output logic              pend2,
   // write port 3 (ALU, wins on address collision)
   input  logic              WE3,
   input  logic [ADDR_W-1:0] A3,
   input  logic [DATA_W-1:0] WD3,
   // write port 4 (load pipe)
   input  logic              WE4,
   input  logic [ADDR_W-1:0] A4,
   input  logic [DATA_W-1:0] WD4,
   // scoreboard reserve
   input  logic              RSV,
   input  logic [ADDR_W-1:0] RA
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam bit ZeroEn = (ZERO_REG != 0);
   localparam bit BypEn  = (BYPASS != 0);
   localparam logic [ADDR_W-1:0] LastIdx = '1;

   typedef enum logic {StSweep, StRun} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
   logic [DEPTH-1:0]    pend_q, pend_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic run;
   logic we3_v, we4_v, rsv_v;
   logic zero1, zero2;
   logic h3_1, h4_1, h3_2, h4_2;

   assign run       = (state_q == StRun);
   assign init_busy = ~run;

   // Effective write/reserve strobes: only in RUN, address 0 is inert when hardwired to zero.
   // we4_v is not masked by a port-3 collision; port 3 priority comes from write ordering below.
   assign we3_v = run && WE3 && !(ZeroEn && (A3 == '0));
   assign we4_v = run && WE4 && !(ZeroEn && (A4 == '0));
   assign rsv_v = run && RSV && !(ZeroEn && (RA == '0));

   assign zero1 = ZeroEn && (A1 == '0);
   assign zero2 = ZeroEn && (A2 == '0);

   // Forwarding hits per read port
   assign h3_1 = BypEn && we3_v && (A3 == A1);
   assign h4_1 = BypEn && we4_v && (A4 == A1);
   assign h3_2 = BypEn && we3_v && (A3 == A2);
   assign h4_2 = BypEn && we4_v && (A4 == A2);

   // Read port 1: forwarded data takes precedence over the stored value
   always_comb begin
      RD1   = '0;
      pend1 = 1'b0;
      if (run && !zero1) begin
         if (h3_1) begin
            RD1 = WD3;
         end else if (h4_1) begin
            RD1 = WD4;
         end else begin
            RD1   = mem_q[A1];
            pend1 = pend_q[A1];
         end
      end
   end

   // Read port 2: same structure as port 1
   always_comb begin
      RD2   = '0;
      pend2 = 1'b0;
      if (run && !zero2) begin
         if (h3_2) begin
            RD2 = WD3;
         end else if (h4_2) begin
            RD2 = WD4;
         end else begin
            RD2   = mem_q[A2];
            pend2 = pend_q[A2];
         end
      end
   end

   // Next-state for the sweep FSM, clear index and scoreboard
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      pend_d    = pend_q;
      unique case (state_q)
         StSweep: begin
            pend_d[clr_idx_q] = 1'b0;
            if (clr_idx_q == LastIdx) begin
               state_d = StRun;
            end else begin
               clr_idx_d = clr_idx_q + 1'b1;
            end
         end
         StRun: begin
            if (we3_v) pend_d[A3] = 1'b0;
            if (we4_v) pend_d[A4] = 1'b0;
            // Reserve applied last so a same-cycle new producer keeps the entry pending
            if (rsv_v) pend_d[RA] = 1'b1;
         end
      endcase
      if (ZeroEn) pend_d[0] = 1'b0;
   end

   // State registers; reset restarts the sweep but leaves the scoreboard to the sweep
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StSweep;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         pend_q    <= pend_d;
      end
   end

   // Storage: sweep clears one entry per cycle; port 3 written last so it wins a collision
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (!run) begin
            mem_q[clr_idx_q] <= '0;
         end else begin
            if (we4_v) mem_q[A4] <= WD4;
            if (we3_v) mem_q[A3] <= WD3;
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, sweep/reset
// sequences and random traffic against an array-based reference model.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   // Shared stimulus for the default build and the no-bypass build
   logic        we3, we4, rsv;
   logic [4:0]  a1, a2, a3, a4, ra;
   logic [31:0] wd3, wd4;
   logic        busy, p1, p2;
   logic [31:0] rd1, rd2;
   logic        nb_busy, nb_p1, nb_p2;
   logic [31:0] nb_rd1, nb_rd2;

   // Small random-traffic build
   logic        r_we3, r_we4, r_rsv;
   logic [2:0]  r_a1, r_a2, r_a3, r_a4, r_ra;
   logic [15:0] r_wd3, r_wd4;
   logic        r_busy, r_p1, r_p2;
   logic [15:0] r_rd1, r_rd2;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_mp dut (
      .clk(clk), .rst(rst), .init_busy(busy),
      .A1(a1), .A2(a2), .RD1(rd1), .RD2(rd2), .pend1(p1), .pend2(p2),
      .WE3(we3), .A3(a3), .WD3(wd3), .WE4(we4), .A4(a4), .WD4(wd4),
      .RSV(rsv), .RA(ra)
   );

   regfile_mp #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .init_busy(nb_busy),
      .A1(a1), .A2(a2), .RD1(nb_rd1), .RD2(nb_rd2), .pend1(nb_p1), .pend2(nb_p2),
      .WE3(we3), .A3(a3), .WD3(wd3), .WE4(we4), .A4(a4), .WD4(wd4),
      .RSV(rsv), .RA(ra)
   );

   regfile_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut_r (
      .clk(clk), .rst(rst), .init_busy(r_busy),
      .A1(r_a1), .A2(r_a2), .RD1(r_rd1), .RD2(r_rd2), .pend1(r_p1), .pend2(r_p2),
      .WE3(r_we3), .A3(r_a3), .WD3(r_wd3), .WE4(r_we4), .A4(r_a4), .WD4(r_wd4),
      .RSV(r_rsv), .RA(r_ra)
   );

   typedef struct {
      logic        we3; logic [4:0] a3; logic [31:0] wd3;
      logic        we4; logic [4:0] a4; logic [31:0] wd4;
      logic        rsv; logic [4:0] ra;
      logic [4:0]  a1;  logic [4:0] a2;
      logic [31:0] rd1; logic [31:0] rd2; logic p1; logic p2;
      logic [31:0] nb1; logic nbp1;
   } vec_t;

   vec_t vt [16];

   // Reference model for the random build
   logic [15:0] m_mem  [8];
   logic        m_pend [8];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we3 = 0; a3 = 0; wd3 = 0; we4 = 0; a4 = 0; wd4 = 0; rsv = 0; ra = 0;
   endtask

   function automatic logic [15:0] m_rd(input logic [2:0] a);
      if (r_we3 && r_a3 == a) return r_wd3;
      if (r_we4 && r_a4 == a) return r_wd4;
      return m_mem[a];
   endfunction

   function automatic logic m_pd(input logic [2:0] a);
      if ((r_we3 && r_a3 == a) || (r_we4 && r_a4 == a)) return 1'b0;
      return m_pend[a];
   endfunction

   initial begin
      int cnt;
      vt[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0};
      vt[1]  = '{1, 0, 32'h1234, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0};
      vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0};
      vt[3]  = '{1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 7, 32'h11, 32'h11, 0, 0, 0, 0};
      vt[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 5, 32'h11, 32'hDEADBEEF, 0, 0, 32'h11, 0};
      vt[5]  = '{0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 0, 0, 0, 0, 0, 0};
      vt[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1, 0, 0, 1};
      vt[7]  = '{0, 0, 0, 1, 9, 32'h77, 0, 0, 9, 0, 32'h77, 0, 0, 0, 0, 1};
      vt[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 32'h77, 0, 0, 0, 32'h77, 0};
      vt[9]  = '{1, 9, 32'h99, 0, 0, 0, 1, 9, 9, 0, 32'h99, 0, 0, 0, 32'h77, 0};
      vt[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 32'h99, 0, 1, 0, 32'h99, 1};
      vt[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vt[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vt[13] = '{1, 13, 32'hCD, 1, 12, 32'hAB, 0, 0, 12, 13, 32'hAB, 32'hCD, 0, 0, 0, 0};
      vt[14] = '{0, 0, 0, 0, 0, 0, 1, 13, 12, 13, 32'hAB, 32'hCD, 0, 0, 32'hAB, 0};
      vt[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 12, 13, 32'hAB, 32'hCD, 0, 1, 32'hAB, 0};

      idle();
      a1 = 0; a2 = 0;
      r_we3 = 0; r_we4 = 0; r_rsv = 0; r_a1 = 0; r_a2 = 0; r_a3 = 0; r_a4 = 0; r_ra = 0;
      r_wd3 = 0; r_wd4 = 0;

      // Reset for one cycle, then the sweep must take exactly 32 cycles
      rst = 1;
      tick();
      rst = 0;
      check("busy_after_rst", {31'd0, busy}, 1);
      cnt = 0;
      while (busy && cnt < 100) begin
         a1 = cnt[4:0];
         #2;
         check("sweep_rd1", rd1, 0);
         check("sweep_pend1", {31'd0, p1}, 0);
         tick();
         cnt++;
      end
      check("sweep_len", cnt, 32);
      check("nb_busy_done", {31'd0, nb_busy}, 0);
      check("r_busy_done", {31'd0, r_busy}, 0);
      for (int i = 0; i < 32; i++) begin
         a1 = 5'(i);
         #1;
         check("post_sweep_rd1", rd1, 0);
         check("post_sweep_pend1", {31'd0, p1}, 0);
      end

      // Directed vector table: writes, collisions, forwarding, scoreboard
      for (int i = 0; i < 16; i++) begin
         we3 = vt[i].we3; a3 = vt[i].a3; wd3 = vt[i].wd3;
         we4 = vt[i].we4; a4 = vt[i].a4; wd4 = vt[i].wd4;
         rsv = vt[i].rsv; ra = vt[i].ra; a1 = vt[i].a1; a2 = vt[i].a2;
         #2;
         check($sformatf("v%0d_rd1", i), rd1, vt[i].rd1);
         check($sformatf("v%0d_rd2", i), rd2, vt[i].rd2);
         check($sformatf("v%0d_p1", i), {31'd0, p1}, {31'd0, vt[i].p1});
         check($sformatf("v%0d_p2", i), {31'd0, p2}, {31'd0, vt[i].p2});
         check($sformatf("v%0d_nb_rd1", i), nb_rd1, vt[i].nb1);
         check($sformatf("v%0d_nb_p1", i), {31'd0, nb_p1}, {31'd0, vt[i].nbp1});
         tick();
      end
      idle();

      // Reset restarted mid-sweep; writes during the sweep are ignored
      we3 = 1; a3 = 3; wd3 = 32'h55;
      tick();
      idle();
      a1 = 3;
      #2;
      check("reg3_written", rd1, 32'h55);
      rst = 1;
      tick();
      rst = 0;
      we3 = 1; a3 = 3; wd3 = 32'h66;
      for (int k = 0; k < 10; k++) tick();
      #2;
      check("mid_sweep_busy", {31'd0, busy}, 1);
      check("mid_sweep_rd1", rd1, 0);
      rst = 1;
      tick();
      rst = 0;
      cnt = 0;
      while (busy && cnt < 100) begin
         tick();
         cnt++;
      end
      check("restart_sweep_len", cnt, 32);
      idle();
      #2;
      check("reg3_cleared", rd1, 0);
      check("nb_reg3_cleared", nb_rd1, 0);

      // Random traffic on the small build against the array model
      for (int i = 0; i < 8; i++) begin
         m_mem[i]  = '0;
         m_pend[i] = 1'b0;
      end
      for (int c = 0; c < 2000; c++) begin
         r_we3 = 1'($urandom_range(0, 1)); r_a3 = 3'($urandom_range(0, 7)); r_wd3 = 16'($urandom);
         r_we4 = 1'($urandom_range(0, 1)); r_a4 = 3'($urandom_range(0, 7)); r_wd4 = 16'($urandom);
         r_rsv = 1'($urandom_range(0, 1)); r_ra = 3'($urandom_range(0, 7));
         r_a1  = 3'($urandom_range(0, 7)); r_a2 = 3'($urandom_range(0, 7));
         #2;
         check("rnd_rd1", {16'd0, r_rd1}, {16'd0, m_rd(r_a1)});
         check("rnd_rd2", {16'd0, r_rd2}, {16'd0, m_rd(r_a2)});
         check("rnd_p1", {31'd0, r_p1}, {31'd0, m_pd(r_a1)});
         check("rnd_p2", {31'd0, r_p2}, {31'd0, m_pd(r_a2)});
         if (r_we4) begin
            m_mem[r_a4]  = r_wd4;
            m_pend[r_a4] = 1'b0;
         end
         if (r_we3) begin
            m_mem[r_a3]  = r_wd3;
            m_pend[r_a3] = 1'b0;
         end
         if (r_rsv) m_pend[r_ra] = 1'b1;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
